// File: rtl/sram_bank_responder_if.sv
// Muxed requester bus seen by the SRAM bank: access request from the 2:1 mux
// (master side) and per-requester read return plus the sticky range error
// (slave side). Widths come from `ADDR_WIDTH / `DATA_WIDTH.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface sram_bank_responder_if;
  logic                   sel;
  logic [`ADDR_WIDTH-1:0] A;
  logic [`DATA_WIDTH-1:0] D;
  logic                   CEN;
  logic                   WEN;
  logic [`DATA_WIDTH-1:0] Q_0;
  logic [`DATA_WIDTH-1:0] Q_1;
  logic                   Q_valid_0;
  logic                   Q_valid_1;
  logic                   addr_err;

  modport master (
    output sel, A, D, CEN, WEN,
    input  Q_0, Q_1, Q_valid_0, Q_valid_1, addr_err
  );

  modport slave (
    input  sel, A, D, CEN, WEN,
    output Q_0, Q_1, Q_valid_0, Q_valid_1, addr_err
  );
endinterface

// File: rtl/sram_bank_responder.sv
// Single-port SRAM bank behind the FFT requester mux. Reads return on the
// issuing requester's Q_x with a one-cycle Q_valid_x pulse; the other
// requester's Q holds. Out-of-range accesses drop writes, read as zero and
// set a sticky addr_err.
// Optional feature: define SRAM_OUT_REG_EN to add an output pipeline stage
// (read latency 2 instead of 1).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sram_bank_responder #(
  parameter int DEPTH = 2**`ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_bank_responder_if.slave  bus
);
  localparam int AW    = `ADDR_WIDTH;
  localparam int DW    = `DATA_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem_q [DEPTH];

  logic             in_range;
  logic             wr_en;
  logic             rd_en;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    rd_word;

  // Word that reaches the requester and its tag/valid, after the optional stage.
  logic             fin_vld;
  logic             fin_tag;
  logic [DW-1:0]    fin_data;

  logic [DW-1:0]    q0_q, q0_d;
  logic [DW-1:0]    q1_q, q1_d;
  logic             qv0_q, qv0_d;
  logic             qv1_q, qv1_d;
  logic             addr_err_q, addr_err_d;

  // Decode the sampled access; out-of-range reads are forced to zero.
  always_comb begin
    in_range = (32'(bus.A) < 32'(DEPTH));
    idx      = bus.A[IDX_W-1:0];
    wr_en    = !bus.CEN && !bus.WEN && in_range;
    rd_en    = !bus.CEN && bus.WEN;
    rd_word  = in_range ? mem_q[idx] : '0;
  end

  // Array write; the array itself is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= bus.D;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic          pipe_vld_q;
  logic          pipe_tag_q;
  logic [DW-1:0] pipe_data_q;

  // Extra output stage between the array read and the requester ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q  <= 1'b0;
      pipe_tag_q  <= 1'b0;
      pipe_data_q <= '0;
    end else begin
      pipe_vld_q  <= rd_en;
      pipe_tag_q  <= bus.sel;
      pipe_data_q <= rd_word;
    end
  end

  assign fin_vld  = pipe_vld_q;
  assign fin_tag  = pipe_tag_q;
  assign fin_data = pipe_data_q;
`else
  assign fin_vld  = rd_en;
  assign fin_tag  = bus.sel;
  assign fin_data = rd_word;
`endif

  // Route the returning word to its owner; the other Q holds its last value.
  always_comb begin
    q0_d       = q0_q;
    q1_d       = q1_q;
    qv0_d      = 1'b0;
    qv1_d      = 1'b0;
    addr_err_d = addr_err_q;
    if (fin_vld) begin
      if (fin_tag) begin
        q1_d  = fin_data;
        qv1_d = 1'b1;
      end else begin
        q0_d  = fin_data;
        qv0_d = 1'b1;
      end
    end
    if (!bus.CEN && !in_range) begin
      addr_err_d = 1'b1;
    end
  end

  // Read-stage / return registers; rst discards any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_q       <= '0;
      q1_q       <= '0;
      qv0_q      <= 1'b0;
      qv1_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      qv0_q      <= qv0_d;
      qv1_q      <= qv1_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.Q_0       = q0_q;
  assign bus.Q_1       = q1_q;
  assign bus.Q_valid_0 = qv0_q;
  assign bus.Q_valid_1 = qv1_q;
  assign bus.addr_err  = addr_err_q;

  logic unused_ok;
  assign unused_ok = ^{bus.A[AW-1:0]};
endmodule

// File: tb/tb_sram_bank_responder.sv
// Directed bench for sram_bank_responder with DEPTH=16 on a 5-bit address.
// Reads push an expected {owner, data, due cycle} onto a scoreboard; a
// negedge monitor pops it when due and checks valids and both Q ports
// against a model of the last delivered value per requester.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_sram_bank_responder;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic        tag;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  logic [15:0] q0_m = '0;
  logic [15:0] q1_m = '0;

  sram_bank_responder_if bus();

  sram_bank_responder #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic op(input logic cen, input logic wen, input logic s,
                    input logic [4:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
    exp_t e;
    bus.CEN = cen;
    bus.WEN = wen;
    bus.sel = s;
    bus.A   = a;
    bus.D   = d;
    if (!cen && wen) begin
      e.tag  = s;
      e.data = exp_rd;
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic s);
    op(1'b0, 1'b0, s, a, d, 16'h0);
  endtask

  task automatic rd(input logic [4:0] a, input logic s, input logic [15:0] exp_rd);
    op(1'b0, 1'b1, s, a, 16'h0, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b1, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0);
  endtask

  // Per-cycle response monitor.
  always @(negedge clk) begin
    logic ev0, ev1;
    exp_t e;
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rst) begin
      q0_m = '0;
      q1_m = '0;
      check("rst_addr_err", 32'(bus.addr_err), 32'd0);
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("due_cycle", 32'(e.due), 32'(cyc));
      if (e.tag) begin
        q1_m = e.data;
        ev1  = 1'b1;
      end else begin
        q0_m = e.data;
        ev0  = 1'b1;
      end
    end
    check("Q_valid_0", 32'(bus.Q_valid_0), 32'(ev0));
    check("Q_valid_1", 32'(bus.Q_valid_1), 32'(ev1));
    check("Q_0", 32'(bus.Q_0), 32'(q0_m));
    check("Q_1", 32'(bus.Q_1), 32'(q1_m));
  end

  initial begin
    bus.CEN = 1'b1;
    bus.WEN = 1'b1;
    bus.sel = 1'b0;
    bus.A   = '0;
    bus.D   = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_addr_err", 32'(bus.addr_err), 32'd0);

    // Owner 0 write then read.
    wr(5'd5, 16'h1234, 1'b0);
    rd(5'd5, 1'b0, 16'h1234);
    idle(LAT + 1);
    check("owner0_Q_0", 32'(bus.Q_0), 32'h1234);
    check("owner0_Q_1_held", 32'(bus.Q_1), 32'h0);

    // Alternating owners, back to back.
    wr(5'd1, 16'hAAAA, 1'b0);
    wr(5'd2, 16'h5555, 1'b1);
    rd(5'd1, 1'b0, 16'hAAAA);
    rd(5'd2, 1'b1, 16'h5555);
    idle(LAT + 1);
    check("alt_Q_0_held", 32'(bus.Q_0), 32'hAAAA);
    check("alt_Q_1", 32'(bus.Q_1), 32'h5555);

    // Read-after-write on consecutive edges.
    wr(5'd7, 16'hBEEF, 1'b1);
    rd(5'd7, 1'b1, 16'hBEEF);
    idle(LAT + 1);

    // Idle then write: monitor requires no valid pulses.
    idle(10);
    wr(5'd3, 16'h0303, 1'b1);
    idle(3);

    // Out of range.
    wr(5'd4, 16'h4444, 1'b0);
    wr(5'd15, 16'h0F0F, 1'b1);
    check("inrange_no_err", 32'(bus.addr_err), 32'd0);
    wr(5'd20, 16'hFFFF, 1'b0);
    check("oor_write_err", 32'(bus.addr_err), 32'd1);
    rd(5'd4, 1'b0, 16'h4444);
    rd(5'd20, 1'b1, 16'h0000);
    rd(5'd15, 1'b0, 16'h0F0F);
    rd(5'd16, 1'b0, 16'h0000);
    rd(5'd3, 1'b1, 16'h0303);
    idle(LAT + 2);
    check("oor_err_sticky", 32'(bus.addr_err), 32'd1);

    // Back-to-back alternating stream.
    rd(5'd1, 1'b1, 16'hAAAA);
    rd(5'd2, 1'b0, 16'h5555);
    rd(5'd5, 1'b1, 16'h1234);
    rd(5'd7, 1'b0, 16'hBEEF);
    idle(LAT + 2);

    // Reset with a read in flight.
    bus.CEN = 1'b0;
    bus.WEN = 1'b1;
    bus.sel = 1'b1;
    bus.A   = 5'd5;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.CEN = 1'b1;
    sb.delete();
    #1;
    check("midrst_Q_valid_1", 32'(bus.Q_valid_1), 32'd0);
    check("midrst_Q_1", 32'(bus.Q_1), 32'd0);
    check("midrst_Q_0", 32'(bus.Q_0), 32'd0);
    check("midrst_addr_err", 32'(bus.addr_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    rd(5'd5, 1'b0, 16'h1234);
    idle(LAT + 2);
    check("post_rst_Q_0", 32'(bus.Q_0), 32'h1234);
    check("post_rst_addr_err", 32'(bus.addr_err), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_bank_responder.md
# sram_bank_responder

Single-port synchronous memory bank that sits on the far side of the 2:1 requester mux in the FFT datapath. It consumes the muxed address/data/CEN/WEN bus plus the mux select, performs the write or read, and returns read data to the requester that issued it, using a registered owner tag. Read latency is fixed at 1 cycle, or 2 with the optional output register.

## Interface
- DEPTH, default 2**`ADDR_WIDTH: number of words implemented; addresses >= DEPTH are out of range.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  owner of the current access: 0 = requester 0, 1 = requester 1; same value as the mux select.
- A  in  `ADDR_WIDTH  word address.
- D  in  `DATA_WIDTH  write data.
- CEN  in  1  chip enable, active-low.
- WEN  in  1  write enable, active-low; only meaningful when CEN=0.
- Q_0  out  `DATA_WIDTH  read data for requester 0.
- Q_1  out  `DATA_WIDTH  read data for requester 1.
- Q_valid_0  out  1  one-cycle pulse: Q_0 carries new read data.
- Q_valid_1  out  1  one-cycle pulse: Q_1 carries new read data.
- addr_err  out  1  sticky flag: an out-of-range access occurred.

## Operation
- The access type is sampled on each rising clk edge:
  - CEN=1: idle; no state change.
  - CEN=0, WEN=0: write. mem[A] <= D. No read data is produced and no valid pulse is raised.
  - CEN=0, WEN=1: read. mem[A] is captured into the read stage, and the owner tag is captured from sel.
- Read return:
  - The data is driven on Q_<tag> together with a Q_valid_<tag> pulse.
  - The other requester's Q holds its last value, and its valid stays 0.
  - Q_0 and Q_1 hold their last delivered value until that owner's next read completes.
- Out-of-range access (A >= DEPTH, CEN=0):
  - A write is dropped; memory is unchanged.
  - A read returns 0 with a normal valid pulse to the owner.
  - addr_err sets and stays 1 until rst.
- Back-to-back reads are accepted every cycle, and they may alternate owners. Each read returns in issue order with its own tag.
- Read-after-write to the same address in consecutive cycles returns the newly written data, because the write completes at edge N and the read samples at edge N+1.
- No same-cycle read/write collision exists, since the bank is a single port.
- The memory array is not reset; contents are undefined until written.

## Timing
- Reset values: Q_0 = 0, Q_1 = 0, Q_valid_0 = 0, Q_valid_1 = 0, addr_err = 0. The read-stage valid and tag also clear.
- rst asserted mid-read: the pending read is discarded and no valid pulse follows after rst deasserts. A write sampled before rst asserted has already completed.
- Latency without the output register: a read sampled at edge N produces data and valid in the cycle after edge N; valid is high for exactly one cycle.
- Latency with the output register: a read sampled at edge N produces data and valid in the cycle after edge N+1.
- Throughput is 1 access per cycle in both modes.
- addr_err asserts in the cycle after the offending edge.
- Inputs must be stable around the clk edge. sel is sampled on the same edge as A/CEN/WEN.

## Configuration
- SRAM_OUT_REG_EN defined:
  - Adds a second pipeline stage (data, tag, valid) between the array read and Q_x/Q_valid_x.
  - Read latency becomes 2 cycles.
  - The extra stage resets to 0 and is flushed by rst like the first.
- SRAM_OUT_REG_EN undefined: read latency is 1 cycle; only the read stage exists.
- Ordering, tag routing and addr_err behaviour are identical in both builds.

## Test plan
- Write/read, owner 0: write A=5, D=0x1234 with sel=0; then read A=5 with sel=0 -> Q_0 = 0x1234 and Q_valid_0 pulses at the configured latency; Q_1 and Q_valid_1 unchanged.
- Alternating owners:
  - Stimulus: preload mem[1] = 0xAAAA and mem[2] = 0x5555. Read A=1 sel=0, then A=2 sel=1 on consecutive cycles.
  - Response: Q_0 = 0xAAAA then Q_1 = 0x5555 on consecutive cycles. Each valid pulses for exactly 1 cycle, and Q_0 still holds 0xAAAA afterwards.
- Read-after-write: write A=7, D=0xBEEF at edge N; read A=7 at edge N+1 -> returned data is 0xBEEF.
- Idle and write produce no response: CEN=1 for 10 cycles, then a write with CEN=0 WEN=0 -> no valid pulses; Q_0 and Q_1 unchanged.
- Out of range (DEPTH=16, ADDR_WIDTH=5):
  - Write A=20 with D=0xFFFF -> mem[4] unchanged, and addr_err = 1 in the next cycle.
  - Read A=20 with sel=1 -> Q_1 = 0 with a Q_valid_1 pulse; addr_err remains 1 until rst.
- Reset mid-read: issue a read, assert rst in the next cycle -> no valid pulse, all outputs 0. After rst deasserts, a new read returns normally.
